// File: rtl/traffic_lamp_decoder_pkg.sv
// Shared phase-code, lamp-vector and fault-cause definitions for the lamp-driver board.
// Decode helpers are kept here so the filter and the top agree on a single code map.
package traffic_pkg;

  typedef logic [4:0]  code_t;
  typedef logic [11:0] lamp_t;

  localparam code_t PH_NS_LEFT_GO  = 5'd0;
  localparam code_t PH_NS_LEFT_CLR = 5'd1;
  localparam code_t PH_NS_LEFT_END = 5'd2;
  localparam code_t PH_NS_GO_PERM  = 5'd3;
  localparam code_t PH_NS_GO       = 5'd4;
  localparam code_t PH_NS_CLR      = 5'd5;
  localparam code_t PH_NS_ALL_RED  = 5'd6;
  localparam code_t PH_NS_WALK     = 5'd7;
  localparam code_t PH_NS_WALK_CLR = 5'd8;
  localparam code_t PH_RESERVED    = 5'd9;
  localparam code_t PH_EW_LEFT_GO  = 5'd10;
  localparam code_t PH_EW_LEFT_CLR = 5'd11;
  localparam code_t PH_EW_LEFT_END = 5'd12;
  localparam code_t PH_EW_GO_PERM  = 5'd13;
  localparam code_t PH_EW_GO       = 5'd14;
  localparam code_t PH_EW_CLR      = 5'd15;
  localparam code_t PH_EW_ALL_RED  = 5'd16;
  localparam code_t PH_EW_WALK     = 5'd17;
  localparam code_t PH_EW_WALK_CLR = 5'd18;

  localparam logic [1:0] CAUSE_NONE          = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL_CODE  = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL_TRANS = 2'b10;
  localparam logic [1:0] CAUSE_WATCHDOG      = 2'b11;

  // Lamp-vector bit positions: NS group, EW group, then the two walk lamps.
  localparam int L_NS_RED      = 11;
  localparam int L_NS_YEL      = 10;
  localparam int L_NS_GRN      = 9;
  localparam int L_NS_LEFT_GRN = 8;
  localparam int L_NS_LEFT_YEL = 7;
  localparam int L_EW_RED      = 6;
  localparam int L_EW_YEL      = 5;
  localparam int L_EW_GRN      = 4;
  localparam int L_EW_LEFT_GRN = 3;
  localparam int L_EW_LEFT_YEL = 2;
  localparam int L_NS_WALK     = 1;
  localparam int L_EW_WALK     = 0;

  function automatic logic is_legal_code(input code_t c);
    return (c <= PH_EW_WALK_CLR) && (c != PH_RESERVED);
  endfunction

  function automatic logic is_successor(input code_t cur, input code_t nxt);
    case (cur)
      PH_NS_LEFT_GO:  return nxt == PH_NS_LEFT_CLR;
      PH_NS_LEFT_CLR: return nxt == PH_NS_LEFT_END;
      PH_NS_LEFT_END: return (nxt == PH_NS_GO_PERM) || (nxt == PH_NS_WALK);
      PH_NS_GO_PERM:  return (nxt == PH_NS_GO) || (nxt == PH_NS_CLR);
      PH_NS_GO:       return (nxt == PH_NS_GO_PERM) || (nxt == PH_NS_CLR);
      PH_NS_CLR:      return nxt == PH_NS_ALL_RED;
      PH_NS_ALL_RED:  return nxt == PH_EW_LEFT_GO;
      PH_NS_WALK:     return nxt == PH_NS_WALK_CLR;
      PH_NS_WALK_CLR: return nxt == PH_NS_ALL_RED;
      PH_EW_LEFT_GO:  return nxt == PH_EW_LEFT_CLR;
      PH_EW_LEFT_CLR: return nxt == PH_EW_LEFT_END;
      PH_EW_LEFT_END: return (nxt == PH_EW_GO_PERM) || (nxt == PH_EW_WALK);
      PH_EW_GO_PERM:  return (nxt == PH_EW_GO) || (nxt == PH_EW_CLR);
      PH_EW_GO:       return (nxt == PH_EW_GO_PERM) || (nxt == PH_EW_CLR);
      PH_EW_CLR:      return nxt == PH_EW_ALL_RED;
      PH_EW_ALL_RED:  return nxt == PH_NS_LEFT_GO;
      PH_EW_WALK:     return nxt == PH_EW_WALK_CLR;
      PH_EW_WALK_CLR: return nxt == PH_EW_ALL_RED;
      default:        return 1'b0;
    endcase
  endfunction

  // EW phases are decoded as their NS twin and then the two halves swapped.
  function automatic lamp_t decode_lamps(input code_t c, input logic blink);
    lamp_t l;
    logic  ew_side;
    code_t base;
    l       = '0;
    ew_side = (c >= PH_EW_LEFT_GO);
    base    = ew_side ? code_t'(c - 5'd10) : c;
    case (base)
      PH_NS_LEFT_GO:  begin l[L_NS_LEFT_GRN] = 1'b1; l[L_NS_RED] = 1'b1; l[L_EW_RED] = 1'b1; end
      PH_NS_LEFT_CLR: begin l[L_NS_LEFT_YEL] = 1'b1; l[L_NS_RED] = 1'b1; l[L_EW_RED] = 1'b1; end
      PH_NS_LEFT_END: begin l[L_NS_RED] = 1'b1; l[L_EW_RED] = 1'b1; end
      PH_NS_GO_PERM:  begin l[L_NS_GRN] = 1'b1; l[L_NS_LEFT_YEL] = 1'b1; l[L_EW_RED] = 1'b1; end
      PH_NS_GO:       begin l[L_NS_GRN] = 1'b1; l[L_EW_RED] = 1'b1; end
      PH_NS_CLR:      begin l[L_NS_YEL] = 1'b1; l[L_EW_RED] = 1'b1; end
      PH_NS_ALL_RED:  begin l[L_NS_RED] = 1'b1; l[L_EW_RED] = 1'b1; end
      PH_NS_WALK:     begin l[L_NS_GRN] = 1'b1; l[L_NS_WALK] = 1'b1; l[L_EW_RED] = 1'b1; end
      PH_NS_WALK_CLR: begin l[L_NS_YEL] = 1'b1; l[L_NS_WALK] = blink; l[L_EW_RED] = 1'b1; end
      default:        l = '0;
    endcase
    return ew_side ? {l[6:2], l[11:7], l[0], l[1]} : l;
  endfunction

endpackage

// File: rtl/traffic_lamp_decoder_code_sync_filter.sv
// Two-flop synchroniser on the controller phase pins plus a stability filter that
// pulses cand_valid once each time a synchronised value has held for STABLE_CYCLES samples.
module code_sync_filter
  import traffic_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic  slowclk,
  input  logic  reset,
  input  code_t code_in,
  output code_t cand,
  output logic  cand_valid
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  code_t            sync1_q, sync1_d;
  code_t            sync2_q, sync2_d;
  code_t            last_q, last_d;
  logic [1:0]       vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             restart;

  // vld_q marks when sync2_q holds a real pin sample rather than its reset value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sync1_d = code_in;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    last_d  = last_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    restart = vld_q[1] && ((cnt_q == '0) || (sync2_q != last_q));
    if (restart) begin
      last_d  = sync2_q;
      cnt_d   = CNT_W'(1);
      valid_d = (STABLE_CYCLES == 1);
    end else if (vld_q[1] && (cnt_q != CNT_W'(STABLE_CYCLES))) begin
      cnt_d   = cnt_q + 1'b1;
      valid_d = (cnt_q == CNT_W'(STABLE_CYCLES - 1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge slowclk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      last_q  <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign cand       = last_q;
  assign cand_valid = valid_q;

endmodule

// File: rtl/traffic_lamp_decoder.sv
// Lamp-driver end of the phase-code link: validates each accepted code against the
// phase sequence, drives the lamps, and falls back to flashing all-way red on any fault.
module traffic_lamp_decoder
  import traffic_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FLASH_HALF    = 3125000,
  parameter int unsigned WDOG_CYCLES   = 50000000
) (
  input  logic       slowclk,
  input  logic       reset,
  input  logic [4:0] code_in,
  output logic       ns_red,
  output logic       ns_yel,
  output logic       ns_grn,
  output logic       ns_left_grn,
  output logic       ns_left_yel,
  output logic       ew_red,
  output logic       ew_yel,
  output logic       ew_grn,
  output logic       ew_left_grn,
  output logic       ew_left_yel,
  output logic       ns_walk,
  output logic       ew_walk,
  output logic       fault,
  output logic [1:0] fault_cause
);

  localparam int WDOG_W  = $clog2(WDOG_CYCLES + 1);
  localparam int FLASH_W = $clog2(FLASH_HALF + 1);

  localparam logic [1:0] ST_UNLOCKED = 2'b00;
  localparam logic [1:0] ST_LOCKED   = 2'b01;
  localparam logic [1:0] ST_FAULT    = 2'b10;

  localparam lamp_t ALL_RED = lamp_t'((1 << L_NS_RED) | (1 << L_EW_RED));

  code_t              cand;
  logic               cand_valid;

  logic [1:0]         state_q, state_d;
  code_t              code_q, code_d;
  logic [1:0]         cause_q, cause_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               flash_on_q, flash_on_d;
  lamp_t              lamps_q, lamps_d;
  logic               wd_expire, flash_restart;

  code_sync_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .slowclk    (slowclk),
    .reset      (reset),
    .code_in    (code_in),
    .cand       (cand),
    .cand_valid (cand_valid)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    cause_d   = cause_q;
    wdog_d    = wdog_q + 1'b1;
    wd_expire = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
    case (state_q)
      ST_UNLOCKED: begin
        if (cand_valid) begin
          wdog_d = '0;
          if (!is_legal_code(cand)) begin
            state_d = ST_FAULT;
            cause_d = CAUSE_ILLEGAL_CODE;
          end else begin
            state_d = ST_LOCKED;
            code_d  = cand;
          end
        end else if (wd_expire) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_WATCHDOG;
          wdog_d  = '0;
        end
      end
      ST_LOCKED: begin
        // A repeat of the displayed code is not a change, so it cannot feed the watchdog.
        if (cand_valid && (cand != code_q)) begin
          wdog_d = '0;
          if (!is_legal_code(cand)) begin
            state_d = ST_FAULT;
            cause_d = CAUSE_ILLEGAL_CODE;
          end else if (!is_successor(code_q, cand)) begin
            state_d = ST_FAULT;
            cause_d = CAUSE_ILLEGAL_TRANS;
          end else begin
            code_d = cand;
          end
        end else if (wd_expire) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_WATCHDOG;
          wdog_d  = '0;
        end
      end
      ST_FAULT: begin
        wdog_d = '0;
        if (cand_valid && (cand == PH_NS_LEFT_GO)) begin
          state_d = ST_LOCKED;
          code_d  = PH_NS_LEFT_GO;
          cause_d = CAUSE_NONE;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        wdog_d  = '0;
      end
    endcase
  end

  // Flash phase restarts "on" whenever a flashing display is newly entered.
  always_comb begin
    flash_restart = ((state_d == ST_FAULT) && (state_q != ST_FAULT)) ||
                    ((state_d == ST_LOCKED) &&
                     ((state_q != ST_LOCKED) || (code_d != code_q)) &&
                     ((code_d == PH_NS_WALK_CLR) || (code_d == PH_EW_WALK_CLR)));
    flash_cnt_d = flash_cnt_q + 1'b1;
    flash_on_d  = flash_on_q;
    if (flash_restart) begin
      flash_cnt_d = '0;
      flash_on_d  = 1'b1;
    end else if (flash_cnt_q == FLASH_W'(FLASH_HALF - 1)) begin
      flash_cnt_d = '0;
      flash_on_d  = !flash_on_q;
    end
    case (state_d)
      ST_LOCKED: lamps_d = decode_lamps(code_d, flash_on_d);
      ST_FAULT:  lamps_d = flash_on_d ? ALL_RED : '0;
      default:   lamps_d = ALL_RED;
    endcase
  end

  always_ff @(posedge slowclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_UNLOCKED;
      code_q      <= '0;
      cause_q     <= CAUSE_NONE;
      wdog_q      <= '0;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b0;
      lamps_q     <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cause_q     <= cause_d;
      wdog_q      <= wdog_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      lamps_q     <= lamps_d;
    end
  end

  assign ns_red      = lamps_q[L_NS_RED];
  assign ns_yel      = lamps_q[L_NS_YEL];
  assign ns_grn      = lamps_q[L_NS_GRN];
  assign ns_left_grn = lamps_q[L_NS_LEFT_GRN];
  assign ns_left_yel = lamps_q[L_NS_LEFT_YEL];
  assign ew_red      = lamps_q[L_EW_RED];
  assign ew_yel      = lamps_q[L_EW_YEL];
  assign ew_grn      = lamps_q[L_EW_GRN];
  assign ew_left_grn = lamps_q[L_EW_LEFT_GRN];
  assign ew_left_yel = lamps_q[L_EW_LEFT_YEL];
  assign ns_walk     = lamps_q[L_NS_WALK];
  assign ew_walk     = lamps_q[L_EW_WALK];
  assign fault       = (state_q == ST_FAULT);
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_traffic_lamp_decoder.sv
// Self-checking bench for traffic_lamp_decoder: table-driven phase vectors plus
// hand-written fault, watchdog and flash sequences, all checked through a timed scoreboard.
module tb_traffic_lamp_decoder;

  localparam int S  = 4;
  localparam int FH = 8;
  localparam int WD = 1000;

  typedef logic [11:0] lv_t;
  // Bench-side lamp masks, ordered as the observed vector below.
  localparam lv_t NR  = 12'h800, NY  = 12'h400, NG  = 12'h200, NLG = 12'h100;
  localparam lv_t NLY = 12'h080, ER  = 12'h040, EY  = 12'h020, EG  = 12'h010;
  localparam lv_t ELG = 12'h008, ELY = 12'h004, NWK = 12'h002, EWK = 12'h001;

  localparam lv_t T0  = NR | ER | NLG;
  localparam lv_t T1  = NR | ER | NLY;
  localparam lv_t T2  = NR | ER;
  localparam lv_t T3  = NG | NLY | ER;
  localparam lv_t T4  = NG | ER;
  localparam lv_t T5  = NY | ER;
  localparam lv_t T6  = NR | ER;
  localparam lv_t T7  = NG | NWK | ER;
  localparam lv_t T8N = NY | NWK | ER;
  localparam lv_t T8F = NY | ER;
  localparam lv_t T10 = ER | NR | ELG;
  localparam lv_t T11 = ER | NR | ELY;
  localparam lv_t T12 = ER | NR;
  localparam lv_t T16 = ER | NR;
  localparam lv_t T17 = EG | EWK | NR;
  localparam lv_t T18N = EY | EWK | NR;
  localparam lv_t T18F = EY | NR;

  localparam logic [2:0] FC_OK    = 3'b0_00;
  localparam logic [2:0] FC_CODE  = 3'b1_01;
  localparam logic [2:0] FC_TRANS = 3'b1_10;
  localparam logic [2:0] FC_WDOG  = 3'b1_11;

  typedef struct {
    logic [4:0] code;
    int         hold;
    lv_t        l0;
    logic [2:0] fc0;
    lv_t        l1;
    logic [2:0] fc1;
  } vec_t;

  typedef struct {
    int          due;
    logic [14:0] val;
    string       name;
  } exp_t;

  logic       slowclk = 1'b0;
  logic       reset;
  logic [4:0] code_in;
  logic       ns_red, ns_yel, ns_grn, ns_left_grn, ns_left_yel;
  logic       ew_red, ew_yel, ew_grn, ew_left_grn, ew_left_yel;
  logic       ns_walk, ew_walk, fault;
  logic [1:0] fault_cause;
  logic [14:0] obs;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  vec_t tbl[$];
  vec_t tbl2[$];

  traffic_lamp_decoder #(
    .STABLE_CYCLES (S),
    .FLASH_HALF    (FH),
    .WDOG_CYCLES   (WD)
  ) dut (
    .slowclk     (slowclk),
    .reset       (reset),
    .code_in     (code_in),
    .ns_red      (ns_red),
    .ns_yel      (ns_yel),
    .ns_grn      (ns_grn),
    .ns_left_grn (ns_left_grn),
    .ns_left_yel (ns_left_yel),
    .ew_red      (ew_red),
    .ew_yel      (ew_yel),
    .ew_grn      (ew_grn),
    .ew_left_grn (ew_left_grn),
    .ew_left_yel (ew_left_yel),
    .ns_walk     (ns_walk),
    .ew_walk     (ew_walk),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  always #5 slowclk = ~slowclk;
  always @(posedge slowclk) cyc <= cyc + 1;

  assign obs = {ns_red, ns_yel, ns_grn, ns_left_grn, ns_left_yel,
                ew_red, ew_yel, ew_grn, ew_left_grn, ew_left_yel,
                ns_walk, ew_walk, fault, fault_cause};

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: each entry is compared at the negedge following its due edge.
  always @(negedge slowclk) begin : sb_checker
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: stale entry due=%0d checked at cycle %0d", e.name, e.due, cyc);
      end else begin
        check(e.name, obs, e.val);
      end
    end
  end

  function automatic lv_t fault_red(input int t, input int e);
    return (((t - e) / FH) % 2 == 0) ? (NR | ER) : lv_t'(0);
  endfunction

  function automatic lv_t walk8(input int t, input int e);
    return (((t - e) / FH) % 2 == 0) ? T8N : T8F;
  endfunction

  task automatic expect_at(input int due, input lv_t l, input logic [2:0] fc, input string name);
    exp_t x;
    x.due  = due;
    x.val  = {l, fc};
    x.name = name;
    sb.push_back(x);
  endtask

  // The edge after the drive samples the new pins; its index is returned in k.
  task automatic drive(input logic [4:0] c, output int k);
    @(negedge slowclk);
    code_in = c;
    k = cyc + 1;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge slowclk);
  endtask

  task automatic apply(input vec_t v);
    int    k;
    string nm;
    drive(v.code, k);
    nm = $sformatf("code%0d@%0d", v.code, k);
    if (v.hold >= S + 3) expect_at(k + S + 2, v.l0, v.fc0, {nm, "/start"});
    expect_at(k + v.hold - 1, v.l1, v.fc1, {nm, "/end"});
    hold(v.hold - 1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge slowclk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s: %0d scoreboard entries never matured", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin : watchdog_timer
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int k, e, a;

    tbl.push_back('{5'd0,  20, T0,   FC_OK, T0,   FC_OK});
    tbl.push_back('{5'd1,  20, T1,   FC_OK, T1,   FC_OK});
    tbl.push_back('{5'd2,  20, T2,   FC_OK, T2,   FC_OK});
    tbl.push_back('{5'd3,  20, T3,   FC_OK, T3,   FC_OK});
    tbl.push_back('{5'd4,  20, T4,   FC_OK, T4,   FC_OK});
    tbl.push_back('{5'd3,  20, T3,   FC_OK, T3,   FC_OK});
    tbl.push_back('{5'd5,  20, T5,   FC_OK, T5,   FC_OK});
    tbl.push_back('{5'd6,  20, T6,   FC_OK, T6,   FC_OK});
    tbl.push_back('{5'd10, 20, T10,  FC_OK, T10,  FC_OK});
    tbl.push_back('{5'd11, 20, T11,  FC_OK, T11,  FC_OK});
    tbl.push_back('{5'd12, 20, T12,  FC_OK, T12,  FC_OK});
    tbl.push_back('{5'd17, 20, T17,  FC_OK, T17,  FC_OK});
    tbl.push_back('{5'd18, 20, T18N, FC_OK, T18F, FC_OK});
    tbl.push_back('{5'd16, 20, T16,  FC_OK, T16,  FC_OK});
    tbl.push_back('{5'd0,  20, T0,   FC_OK, T0,   FC_OK});
    tbl.push_back('{5'd1,  20, T1,   FC_OK, T1,   FC_OK});
    tbl.push_back('{5'd2,  20, T2,   FC_OK, T2,   FC_OK});
    tbl.push_back('{5'd3,  20, T3,   FC_OK, T3,   FC_OK});
    tbl.push_back('{5'd9,   3, T3,   FC_OK, T3,   FC_OK});
    tbl.push_back('{5'd3,  20, T3,   FC_OK, T3,   FC_OK});
    tbl.push_back('{5'd5,  20, T5,   FC_OK, T5,   FC_OK});

    tbl2.push_back('{5'd0, 20, T0, FC_OK, T0, FC_OK});
    tbl2.push_back('{5'd1, 20, T1, FC_OK, T1, FC_OK});
    tbl2.push_back('{5'd2, 20, T2, FC_OK, T2, FC_OK});
    tbl2.push_back('{5'd3, 20, T3, FC_OK, T3, FC_OK});
    tbl2.push_back('{5'd5, 20, T5, FC_OK, T5, FC_OK});

    reset   = 1'b1;
    code_in = 5'd0;
    hold(3);
    check("reset_outputs", obs, 15'd0);

    // Reset release with code 0 held: solid red, then lock at the sixth edge.
    reset = 1'b0;
    k = cyc + 1;
    expect_at(k,         NR | ER, FC_OK, "unlocked_red");
    expect_at(k + S + 1, NR | ER, FC_OK, "unlocked_before_lock");
    expect_at(k + S + 2, T0,      FC_OK, "first_lock_code0");
    hold(S + 6);

    foreach (tbl[i]) apply(tbl[i]);

    // Illegal transition 5 -> 10, flash timing, ignored code, then recovery on 0.
    drive(5'd10, k);
    e = k + S + 2;
    expect_at(e - 1,  T5,               FC_OK,    "trans_before_fault");
    expect_at(e,      fault_red(e, e),      FC_TRANS, "trans_fault_on");
    expect_at(e + 7,  fault_red(e + 7, e),  FC_TRANS, "trans_flash_last_on");
    expect_at(e + 8,  fault_red(e + 8, e),  FC_TRANS, "trans_flash_off");
    expect_at(e + 15, fault_red(e + 15, e), FC_TRANS, "trans_flash_last_off");
    expect_at(e + 16, fault_red(e + 16, e), FC_TRANS, "trans_flash_on_again");
    hold(23);
    drive(5'd1, k);
    expect_at(k + S + 2, fault_red(k + S + 2, e), FC_TRANS, "fault_ignores_code1");
    expect_at(k + 19,    fault_red(k + 19, e),    FC_TRANS, "fault_ignores_code1_end");
    hold(19);
    apply('{5'd0, 20, T0, FC_OK, T0, FC_OK});

    // Illegal code 19.
    drive(5'd19, k);
    e = k + S + 2;
    expect_at(e,      fault_red(e, e),      FC_CODE, "illegal_code_fault");
    expect_at(e + 13, fault_red(e + 13, e), FC_CODE, "illegal_code_hold");
    hold(19);

    foreach (tbl2[i]) apply(tbl2[i]);

    // Watchdog: code 6 held past WD cycles after it was accepted.
    drive(5'd6, k);
    a = k + S + 2;
    expect_at(a,          T6, FC_OK, "wdog_accept6");
    expect_at(a + WD - 1, T6, FC_OK, "wdog_last_ok");
    expect_at(a + WD,     fault_red(a + WD, a + WD),     FC_WDOG, "wdog_fault");
    expect_at(a + WD + 8, fault_red(a + WD + 8, a + WD), FC_WDOG, "wdog_flash_off");
    hold(WD + 15);

    apply('{5'd0, 20, T0, FC_OK, T0, FC_OK});
    apply('{5'd1, 20, T1, FC_OK, T1, FC_OK});
    apply('{5'd2, 20, T2, FC_OK, T2, FC_OK});
    apply('{5'd7, 20, T7, FC_OK, T7, FC_OK});

    // Walk clearance flash, then asynchronous reset in the middle of it.
    drive(5'd8, k);
    e = k + S + 2;
    expect_at(e,      walk8(e, e),      FC_OK, "walk_flash_on");
    expect_at(e + 7,  walk8(e + 7, e),  FC_OK, "walk_flash_last_on");
    expect_at(e + 8,  walk8(e + 8, e),  FC_OK, "walk_flash_off");
    expect_at(e + 15, walk8(e + 15, e), FC_OK, "walk_flash_last_off");
    expect_at(e + 16, walk8(e + 16, e), FC_OK, "walk_flash_on_again");
    hold(23);
    drain("drain_before_reset");
    #1;
    reset = 1'b1;
    #1;
    check("reset_mid_flash", obs, 15'd0);
    hold(2);
    check("reset_held", obs, 15'd0);
    reset = 1'b0;
    hold(1);
    check("post_reset_unlocked", obs, {NR | ER, FC_OK});

    drain("final_drain");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_decoder.md
Name: traffic_lamp_decoder

Overview:
- Receiver end of the 5-bit intersection phase code driven by the signal controller on {JB1,JA4,JA3,JA2,JA1}; sits on the lamp-driver board.
- Synchronises and glitch-filters the code, then checks every code change against the legal phase sequence.
- Decodes the code into individual lamp, arrow and walk drives.
- Forces all-way flashing red on an illegal code, an illegal transition or a stalled controller.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronised samples required before a code is accepted (≥1).
- FLASH_HALF, 3125000: half-period, in slowclk cycles, of every flashing output.
- WDOG_CYCLES, 50000000: maximum cycles without an accepted code change before fault; must exceed the longest phase (46875000).

Ports:
- slowclk in 1: clock.
- reset in 1: asynchronous, active-high.
- code_in in 5: raw phase code from the controller pins; asynchronous, bit0=JA1 … bit4=JB1.
- ns_red, ns_yel, ns_grn out 1 each: NS through lamps.
- ns_left_grn, ns_left_yel out 1 each: NS turn arrow.
- ew_red, ew_yel, ew_grn, ew_left_grn, ew_left_yel out 1 each: EW equivalents of the NS lamps and arrow.
- ns_walk, ew_walk out 1 each: pedestrian walk lamps.
- fault out 1: high while in FAULT.
- fault_cause out 2: 01 illegal code, 10 illegal transition, 11 watchdog; holds its value until fault recovery.

Behaviour:
- Reset: all outputs 0; state UNLOCKED; synchroniser, stability, watchdog and flash counters cleared.
- Synchroniser: 2-flop on code_in.
- Stability filter: counts consecutive cycles with an unchanged synchronised value. At count == STABLE_CYCLES that value becomes the candidate. Shorter glitches are discarded with no effect.
- Latency: a pin change sampled at edge k reaches the registered outputs at edge k+STABLE_CYCLES+2.
- Legal codes: 0-8, 10-18. Codes 9 and 19-31 are illegal.
- Legal successors:
  - 0→1, 1→2, 2→{3,7}, 3→{4,5}, 4→{3,5}, 5→6, 6→10, 7→8, 8→6
  - 10→11, 11→12, 12→{13,17}, 13→{14,15}, 14→{13,15}, 15→16, 16→0, 17→18, 18→16
- A candidate equal to the current code is a no-op.
- States:
  - UNLOCKED: ns_red=ew_red=1 solid. First accepted legal code → LOCKED, displayed directly with no transition check. Illegal code → FAULT (01).
  - LOCKED: legal successor → display it and clear the watchdog. Illegal code → FAULT (01). Legal code but not a successor → FAULT (10).
  - FAULT: ns_red=ew_red flash (on for FLASH_HALF, then off, repeat, starting on); all other lamps 0; fault=1. Accepted code 0 → LOCKED displaying code 0, fault=0, fault_cause=00. Any other code is ignored.
- Watchdog: counts in UNLOCKED and LOCKED, reset on every accepted change. At WDOG_CYCLES → FAULT (11). Disabled in FAULT.
- Fault priority when several causes hit on the same edge: illegal code > illegal transition > watchdog.
- Lamp decode (LOCKED); unlisted lamps are 0:
  - 0: ns_left_grn, ns_red, ew_red
  - 1: ns_left_yel, ns_red, ew_red
  - 2: ns_red, ew_red
  - 3: ns_grn, ns_left_yel, ew_red (permissive-left flash on)
  - 4: ns_grn, ew_red (flash off)
  - 5: ns_yel, ew_red
  - 6: ns_red, ew_red
  - 7: ns_grn, ns_walk, ew_red
  - 8: ns_yel, ew_red, ns_walk flashing at FLASH_HALF
  - 10-18: mirror of 0-8 with NS↔EW swapped
- Flash counter: restarts (output on) on entry to code 8, code 18 or FAULT.
- Reset mid-operation: immediate return to the reset values regardless of state.

Decomposition:
- Shared package traffic_pkg:
  - the 19 phase-code constants, named to match the controller's phase names
  - the 5-bit code type
  - a 12-bit lamp-vector type
  - fault-cause constants
- Sub-module code_sync_filter: 2-flop synchroniser plus stability counter. Outputs a 5-bit cand and a 1-cycle cand_valid pulse on each newly accepted value.

Test Plan (STABLE_CYCLES=4, FLASH_HALF=8, WDOG_CYCLES=1000):
1. Reset release, code_in=0 held → ns_red=ew_red=1, then at edge 6 after the first sample ns_left_grn=1, fault=0.
2. Full cycle 0,1,2,3,4,3,5,6,10,11,12,17,18,16,0, each held 20 cycles → each lamp set matches the decode table; fault stays 0 throughout.
3. Code 3 with a 3-cycle glitch to 9, then back to 3 → no output change, fault=0.
4. From code 5, drive 10 → fault=1, fault_cause=10, ns_red/ew_red toggle every 8 cycles. Then drive 0 → LOCKED, ns_left_grn=1, fault_cause=00.
5. Code 19 held → fault_cause=01. Code 6 held 1000 cycles after acceptance → fault_cause=11.
6. Code 7→8 → ns_walk flashes 8 on / 8 off and ns_yel=1. Reset asserted mid-flash → all outputs 0 on the same edge.
